// File: rtl/sync_fifo_pkg.sv
// Shared elaboration helpers for the single-clock lane FIFO.
package sync_fifo_pkg;

  // Highest supported head-register latency.
  localparam int MAX_READ_CYCLES = 1;

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Write/read handshake bundle of one FIFO lane; the slave side is the FIFO itself.
interface sync_fifo_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 in_valid;
  logic [BIT_WIDTH-1:0] in_data;
  logic                 out_enable;
  logic                 out_valid;
  logic [BIT_WIDTH-1:0] out_data;
  logic                 full;
  logic                 empty;

  modport master (
    output in_valid, in_data, out_enable,
    input  out_valid, out_data, full, empty
  );

  modport slave (
    input  in_valid, in_data, out_enable,
    output out_valid, out_data, full, empty
  );
endinterface

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read address.
module sync_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; validity is tracked by the pointers and count,
  // and leaving it out keeps the array mappable onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock lane FIFO with a valid-flagged head entry, combinational or registered.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int BIT_WIDTH   = 32,
  parameter int DEPTH       = 256,
  parameter int READ_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  sync_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $fatal(1, "sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_next;
  logic [BIT_WIDTH-1:0] rd_data;
  logic                 pop;
  logic                 wr_en;
  logic                 rd_adv;

  assign bus.full  = (count == FULL_COUNT);
  assign bus.empty = (count == '0);

  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign wr_en = bus.in_valid && (!bus.full || pop);

  sync_fifo_mem #(
    .WIDTH (BIT_WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus.in_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // NOTE: default first so every path assigns count_next and no latch is inferred.
  always_comb begin
    count_next = count;
    if (wr_en && !pop)      count_next = count + 1'b1;
    else if (!wr_en && pop) count_next = count - 1'b1;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  if (READ_CYCLES == 0) begin : g_fwft
    // Head is read straight from the array; the read pointer moves on each pop.
    assign bus.out_valid = !bus.empty;
    assign bus.out_data  = rd_data;
    assign pop           = bus.out_enable && !bus.empty;
    assign rd_adv        = pop;
  end else if (READ_CYCLES == MAX_READ_CYCLES) begin : g_oreg
    logic                 oreg_valid;
    logic [BIT_WIDTH-1:0] oreg_data;
    logic                 mem_has_data;
    logic                 load;

    // count includes the head register, so the array holds count minus that entry.
    assign mem_has_data = (count - CW'(oreg_valid)) != '0;
    assign pop          = bus.out_enable && oreg_valid;
    assign load         = mem_has_data && (!oreg_valid || pop);
    assign rd_adv       = load;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        oreg_valid <= 1'b0;
        oreg_data  <= '0;
      end else if (load) begin
        oreg_valid <= 1'b1;
        oreg_data  <= rd_data;
      end else if (pop) begin
        oreg_valid <= 1'b0;
      end
    end

    assign bus.out_valid = oreg_valid;
    assign bus.out_data  = oreg_data;
  end else begin : g_bad_read_cycles
    $fatal(1, "sync_fifo: READ_CYCLES must be 0 or 1");
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: one first-word-fall-through lane and one registered-head lane.
module tb_sync_fifo;

  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sync_fifo_if #(.BIT_WIDTH(W)) bus0 ();
  sync_fifo_if #(.BIT_WIDTH(W)) bus1 ();

  sync_fifo #(.BIT_WIDTH(W), .DEPTH(DEPTH), .READ_CYCLES(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  sync_fifo #(.BIT_WIDTH(W), .DEPTH(DEPTH), .READ_CYCLES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  bit           ov1;          // expected head-register valid of dut1
  int           n_valid_seen; // dut1 cycles observed with out_valid=1

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_enable = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_enable = 1'b0;
  endtask

  // One clock cycle on lane d: compare outputs to the scoreboard, drive, clock, update.
  task automatic step(input int d, input bit wr, input logic [W-1:0] data,
                      input bit req, input string tag);
    int           sz;
    bit           exp_ov, do_pop, do_wr;
    logic         ov, fu, em;
    logic [W-1:0] od, front;
    if (d == 0) begin
      sz = q0.size(); exp_ov = (sz > 0);
      front = (sz > 0) ? q0[0] : '0;
      ov = bus0.out_valid; od = bus0.out_data; fu = bus0.full; em = bus0.empty;
    end else begin
      sz = q1.size(); exp_ov = ov1;
      front = (sz > 0) ? q1[0] : '0;
      ov = bus1.out_valid; od = bus1.out_data; fu = bus1.full; em = bus1.empty;
      if (ov === 1'b1) n_valid_seen++;
    end
    check({tag, ".valid"}, W'(ov), W'(exp_ov));
    check({tag, ".full"},  W'(fu), W'(sz == DEPTH));
    check({tag, ".empty"}, W'(em), W'(sz == 0));
    if (exp_ov) check({tag, ".data"}, od, front);
    do_pop = req && exp_ov;
    do_wr  = wr && ((sz < DEPTH) || do_pop);
    if (d == 0) begin
      bus0.in_valid = wr; bus0.in_data = data; bus0.out_enable = req;
    end else begin
      bus1.in_valid = wr; bus1.in_data = data; bus1.out_enable = req;
    end
    @(posedge clk);
    #1;
    idle();
    if (d == 0) begin
      if (do_pop) void'(q0.pop_front());
      if (do_wr)  q0.push_back(data);
    end else begin
      // Head register refills from storage whenever it is free and storage is non-empty.
      ov1 = (ov1 && !do_pop) || ((sz - int'(ov1)) > 0);
      if (do_pop) void'(q1.pop_front());
      if (do_wr)  q1.push_back(data);
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    ov1 = 1'b0;
    n_valid_seen = 0;
    #11;
    // Test 1: reset state, no stimulus.
    check("rst.empty0", W'(bus0.empty), 1);
    check("rst.full0",  W'(bus0.full), 0);
    check("rst.valid0", W'(bus0.out_valid), 0);
    check("rst.empty1", W'(bus1.empty), 1);
    check("rst.full1",  W'(bus1.full), 0);
    check("rst.valid1", W'(bus1.out_valid), 0);
    check("rst.oreg1",  bus1.out_data, '0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 2: FWFT ordering.
    step(0, 1, 32'hA, 0, "t2w");
    check("t2.visible", W'(bus0.out_valid), 1);
    step(0, 1, 32'hB, 0, "t2w");
    step(0, 1, 32'hC, 0, "t2w");
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, "t2p");
    check("t2.empty", W'(bus0.empty), 1);

    // Test 3: overfill by one; the fifth write is dropped.
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, W'(i), 0, "t3w");
      if (i == 4) check("t3.full_after4", W'(bus0.full), 1);
    end
    check("t3.full", W'(bus0.full), 1);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, "t3p");
    check("t3.drained", W'(bus0.empty), 1);

    // Test 4: write+pop on a full FIFO wraps the pointers and keeps it full.
    for (int i = 0; i < 4; i++) step(0, 1, 32'h40 + W'(i), 0, "t4f");
    step(0, 1, 32'h66, 1, "t4wp");
    check("t4.still_full", W'(bus0.full), 1);
    step(0, 1, 32'h67, 1, "t4wp");
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, "t4p");
    // Write to empty with pop request: nothing popped, entry stored.
    step(0, 1, 32'h77, 1, "t4ew");
    check("t4.stored", W'(bus0.out_valid), 1);
    check("t4.stored_data", bus0.out_data, 32'h77);
    step(0, 0, '0, 1, "t4ep");

    // Test 5: registered head, two-edge latency then unbroken streaming.
    step(1, 0, '0, 1, "t5ign");
    step(1, 1, 32'h55, 0, "t5w");
    check("t5.n_valid", W'(bus1.out_valid), 0);
    step(1, 0, '0, 0, "t5n1");
    check("t5.n1_valid", W'(bus1.out_valid), 1);
    check("t5.n1_data",  bus1.out_data, 32'h55);
    step(1, 1, 32'h56, 0, "t5pre");
    n_valid_seen = 0;
    for (int i = 0; i < 8; i++) step(1, 1, 32'h100 + W'(i), 1, "t5s");
    check("t5.stream_valid_cycles", W'(n_valid_seen), 8);
    for (int i = 0; i < 6; i++) step(1, 0, '0, 1, "t5d");
    check("t5.drained", W'(bus1.empty), 1);

    // Random traffic on both lanes.
    for (int i = 0; i < 60; i++)
      step(0, bit'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 9) < 6, "rnd0");
    for (int i = 0; i < 60; i++)
      step(1, bit'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 9) < 6, "rnd1");

    // Test 6: asynchronous reset mid-stream, away from any clock edge.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h900 + W'(i), 0, "t6f0");
      step(1, 1, 32'h910 + W'(i), 0, "t6f1");
    end
    check("t6.pre_valid1", W'(bus1.out_valid), 1);
    #3 rst_n = 1'b0;
    #1;
    check("t6.valid0", W'(bus0.out_valid), 0);
    check("t6.empty0", W'(bus0.empty), 1);
    check("t6.valid1", W'(bus1.out_valid), 0);
    check("t6.empty1", W'(bus1.empty), 1);
    q0.delete();
    q1.delete();
    ov1 = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    step(0, 1, 32'hBEEF, 0, "t6post0");
    step(0, 0, '0, 1, "t6post0p");
    step(1, 1, 32'hCAFE, 0, "t6post1");
    step(1, 0, '0, 0, "t6post1w");
    step(1, 0, '0, 1, "t6post1p");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
